// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg : types and constants shared by the hazard/stall controller
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_e;

   localparam logic [4:0] REG_ZERO       = 5'd0;
   localparam int         MD_LATENCY_DEF = 4;
   localparam int         MD_CNT_W       = 4;

   // BUSY dwell count loaded on MD entry; EX is held for latency-1 cycles total
   function automatic logic [MD_CNT_W-1:0] md_load(input int latency);
      return MD_CNT_W'(latency - 2);
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detection_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones, async active-low reset
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && !(&count_q)) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_detection.sv
// ----------------------------------------------------------------------------
// hazard_detection : load-use stall, taken-branch flush and MUL/DIV EX hold
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_detection
   import pipeline_pkg::*;
#(
   parameter int MD_LATENCY = MD_LATENCY_DEF,
   parameter int CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       ID_RS_addr_i,
   input  logic [4:0]       ID_RT_addr_i,
   input  logic             ID_uses_RT_i,
   input  logic             EX_MemRead_i,
   input  logic [4:0]       EX_RT_addr_i,
   input  logic             EX_branch_taken_i,
   input  logic             EX_md_i,
   output logic             PC_write_o,
   output logic             IFID_write_o,
   output logic             IFID_flush_o,
   output logic             IDEX_write_o,
   output logic             IDEX_flush_o,
   output logic             EXMEM_flush_o,
   output logic             md_busy_o,
   output logic [CNT_W-1:0] stall_cycles_o
);

   localparam logic [MD_CNT_W-1:0] MD_LOAD = md_load(MD_LATENCY);

   md_state_e           state_q;
   md_state_e           state_d;
   logic [MD_CNT_W-1:0] cnt_q;
   logic [MD_CNT_W-1:0] cnt_d;
   logic                load_use;
   logic                md_stall;

   assign load_use = EX_MemRead_i && (EX_RT_addr_i != REG_ZERO) &&
                     ((EX_RT_addr_i == ID_RS_addr_i) ||
                      (ID_uses_RT_i && (EX_RT_addr_i == ID_RT_addr_i)));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      md_stall = 1'b0;
      unique case (state_q)
         IDLE: begin
            // a taken branch squashes the MD before it starts occupying EX
            if (EX_md_i && !EX_branch_taken_i) begin
               md_stall = 1'b1;
               cnt_d    = MD_LOAD;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               md_stall = 1'b1;
               cnt_d    = cnt_q - {{(MD_CNT_W-1){1'b0}}, 1'b1};
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      PC_write_o    = 1'b1;
      IFID_write_o  = 1'b1;
      IFID_flush_o  = 1'b0;
      IDEX_write_o  = 1'b1;
      IDEX_flush_o  = 1'b0;
      EXMEM_flush_o = 1'b0;
      if (EX_branch_taken_i) begin
         IFID_flush_o = 1'b1;
         IDEX_flush_o = 1'b1;
      end else if (md_stall) begin
         // ID/EX is held here, so a coincident load-use needs no bubble
         PC_write_o    = 1'b0;
         IFID_write_o  = 1'b0;
         IDEX_write_o  = 1'b0;
         EXMEM_flush_o = 1'b1;
      end else if (load_use) begin
         PC_write_o   = 1'b0;
         IFID_write_o = 1'b0;
         IDEX_flush_o = 1'b1;
      end
   end

   assign md_busy_o = (state_q == BUSY);

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_i),
      .inc_i   (!PC_write_o),
      .count_o (stall_cycles_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_hazard_detection.sv
// ----------------------------------------------------------------------------
// tb_hazard_detection : directed checks of the hazard/stall controller
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hazard_detection;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             ex_memread;
   logic [4:0]       ex_rt;
   logic             ex_br;
   logic             ex_md;
   logic             pc_w;
   logic             ifid_w;
   logic             ifid_f;
   logic             idex_w;
   logic             idex_f;
   logic             exmem_f;
   logic             busy;
   logic [CNT_W-1:0] sc;

   int total = 0;
   int bad   = 0;

   hazard_detection #(
      .MD_LATENCY (4),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst_n),
      .ID_RS_addr_i      (id_rs),
      .ID_RT_addr_i      (id_rt),
      .ID_uses_RT_i      (id_uses_rt),
      .EX_MemRead_i      (ex_memread),
      .EX_RT_addr_i      (ex_rt),
      .EX_branch_taken_i (ex_br),
      .EX_md_i           (ex_md),
      .PC_write_o        (pc_w),
      .IFID_write_o      (ifid_w),
      .IFID_flush_o      (ifid_f),
      .IDEX_write_o      (idex_w),
      .IDEX_flush_o      (idex_f),
      .EXMEM_flush_o     (exmem_f),
      .md_busy_o         (busy),
      .stall_cycles_o    (sc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_f}
   task automatic chk_ctl(input string tag, input logic [5:0] exp);
      chk(tag, {26'd0, pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_f}, {26'd0, exp});
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] ert, input logic br,
                        input logic md);
      id_rs = rs; id_rt = rt; id_uses_rt = urt;
      ex_memread = mr; ex_rt = ert; ex_br = br; ex_md = md;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   localparam logic [5:0] DEF   = 6'b110100;
   localparam logic [5:0] LU    = 6'b000110;
   localparam logic [5:0] BR    = 6'b111110;
   localparam logic [5:0] MS    = 6'b000001;

   initial begin
      rst_n = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      chk("reset_sc", {28'd0, sc}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk_ctl("reset_ctl", DEF);
      rst_n = 1'b1;
      tick();

      chk_ctl("default", DEF);

      // load-use through rs
      drive(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      chk_ctl("lu_rs", LU);
      tick();
      chk("lu_rs_sc", {28'd0, sc}, 32'd1);
      drive(5'd5, 5'd9, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
      chk_ctl("lu_clear", DEF);
      tick();
      chk("lu_clear_sc", {28'd0, sc}, 32'd1);

      // $0 and unused rt never stall
      drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      chk_ctl("reg0_no_lu", DEF);
      drive(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
      chk_ctl("rt_unused_no_lu", DEF);
      tick();
      chk("no_lu_sc", {28'd0, sc}, 32'd1);

      drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
      chk_ctl("lu_rt", LU);
      tick();
      chk("lu_rt_sc", {28'd0, sc}, 32'd2);

      // taken branch beats load-use
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
      chk_ctl("br_over_lu", BR);
      tick();
      chk("br_sc", {28'd0, sc}, 32'd2);

      // taken branch beats MD start in IDLE
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      chk_ctl("br_over_md", BR);
      tick();
      chk("br_md_busy", {31'd0, busy}, 32'd0);
      chk("br_md_sc", {28'd0, sc}, 32'd2);

      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      pulse_reset();
      chk("rst_mid_sc", {28'd0, sc}, 32'd0);

      // MD with latency 4: three stall cycles then release
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      chk_ctl("md_c1", MS);
      chk("md_c1_busy", {31'd0, busy}, 32'd0);
      tick();
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
      chk_ctl("md_c2_with_lu", MS);
      chk("md_c2_busy", {31'd0, busy}, 32'd1);
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      chk_ctl("md_c3", MS);
      chk("md_c3_busy", {31'd0, busy}, 32'd1);
      tick();
      chk_ctl("md_c4_release", DEF);
      chk("md_c4_sc", {28'd0, sc}, 32'd3);
      tick();
      chk("md_done_sc", {28'd0, sc}, 32'd3);

      // back-to-back MD restarts from IDLE; async reset in its BUSY cycle 2
      chk("b2b_c1_busy", {31'd0, busy}, 32'd0);
      chk_ctl("b2b_c1", MS);
      tick();
      chk("b2b_c2_busy", {31'd0, busy}, 32'd1);
      chk("b2b_c2_sc", {28'd0, sc}, 32'd4);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_sc", {28'd0, sc}, 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      chk_ctl("post_rst_default", DEF);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      // saturation with a held load-use
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) tick();
      chk("sat_14", {28'd0, sc}, 32'hE);
      tick();
      chk("sat_15", {28'd0, sc}, 32'hF);
      for (int i = 0; i < 5; i++) tick();
      chk("sat_20", {28'd0, sc}, 32'hF);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      chk("sat_hold", {28'd0, sc}, 32'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
